// File: rtl/perceptron_pkg.sv
// Types and constants shared by the sample loader and the training core.
package perceptron_pkg;

    // Loader sequencing: assemble samples, replay them, then wait for clear
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        REPLAY = 2'd1,
        DONE   = 2'd2
    } loader_state_t;

    localparam int DATA_W_DEF   = 8;
    localparam int INP_DIM_DEF  = 2;
    localparam int SAMPLE_W_DEF = INP_DIM_DEF * DATA_W_DEF + DATA_W_DEF;

    // Buffered sample word: label in the top byte, features below it
    typedef struct packed {
        logic [DATA_W_DEF-1:0]             y;
        logic [INP_DIM_DEF*DATA_W_DEF-1:0] x;
    } sample_t;

    // Width of one buffered sample word (features plus label)
    function automatic int sample_width(input int inp_dim, input int data_w);
        return inp_dim * data_w + data_w;
    endfunction

endpackage

// File: rtl/perceptron_sample_buffer.sv
// Sample register file: one synchronous write port, one combinational read port.
module perceptron_sample_buffer #(
    parameter int WORD_W  = 24,
    parameter int N_WORDS = 3,
    parameter int IDX_W   = 2
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [N_WORDS];

    // Write a completed sample; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Combinational read so the presented sample follows rd_idx immediately
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/perceptron_sample_loader.sv
// Assembles samples from a byte stream into a buffer, then replays them
// to the training core for a programmed number of epochs.
module perceptron_sample_loader
    import perceptron_pkg::*;
#(
    parameter int INP_DIM   = 2,
    parameter int N_SAMPLES = 3,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  num_epochs,
    input  logic                        clear,
    output logic                        smp_valid,
    input  logic                        smp_ready,
    output logic [INP_DIM*DATA_W-1:0]   smp_x,
    output logic signed [DATA_W-1:0]    smp_y,
    output logic [IDX_W-1:0]            smp_idx,
    output logic                        smp_last,
    output logic [7:0]                  epoch,
    output logic                        done
);

    localparam int X_W   = INP_DIM * DATA_W;
    localparam int SMP_W = sample_width(INP_DIM, DATA_W);
    localparam int BC_W  = $clog2(INP_DIM + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES - 1);
    localparam logic [BC_W-1:0]  LABEL_CNT = BC_W'(INP_DIM);

    loader_state_t    state_q;
    logic [BC_W-1:0]  byte_cnt_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [7:0]       epoch_q;
    logic [7:0]       ep_target_q;
    logic [X_W-1:0]   stage_q;

    logic             byte_is_label;
    logic             buf_wr_en;
    logic [SMP_W-1:0] buf_wr_data;
    logic [SMP_W-1:0] buf_rd_data;
    logic             last_w;

    assign byte_is_label = (byte_cnt_q == LABEL_CNT);
    // clear drops a same-cycle label, so the buffer write is suppressed too
    assign buf_wr_en     = (state_q == LOAD) && in_valid && byte_is_label && !clear && !rst;
    assign buf_wr_data   = {in_data, stage_q};
    assign last_w        = (state_q == REPLAY) && (rd_idx_q == LAST_IDX)
                           && (epoch_q == ep_target_q - 8'd1);

    perceptron_sample_buffer #(
        .WORD_W  (SMP_W),
        .N_WORDS (N_SAMPLES),
        .IDX_W   (IDX_W)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (buf_wr_en),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (buf_wr_data),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (buf_rd_data)
    );

    // Loader FSM with byte/sample/epoch counters; clear overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            byte_cnt_q  <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            epoch_q     <= '0;
            ep_target_q <= 8'd1;
            stage_q     <= '0;
        end else if (clear) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            epoch_q    <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (byte_is_label) begin
                            byte_cnt_q <= '0;
                            if (wr_idx_q == LAST_IDX) begin
                                wr_idx_q    <= '0;
                                rd_idx_q    <= '0;
                                epoch_q     <= '0;
                                ep_target_q <= (num_epochs == 8'd0) ? 8'd1 : num_epochs;
                                state_q     <= REPLAY;
                            end else begin
                                wr_idx_q <= wr_idx_q + IDX_W'(1);
                            end
                        end else begin
                            stage_q[int'(byte_cnt_q)*DATA_W +: DATA_W] <= in_data;
                            byte_cnt_q <= byte_cnt_q + BC_W'(1);
                        end
                    end
                end
                REPLAY: begin
                    if (smp_ready) begin
                        if (last_w) begin
                            // Epoch is held at its final value while DONE
                            rd_idx_q <= '0;
                            state_q  <= DONE;
                        end else if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q <= '0;
                            epoch_q  <= epoch_q + 8'd1;
                        end else begin
                            rd_idx_q <= rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Outputs decode from registered state; sample fields read as zero outside REPLAY
    assign in_ready  = (state_q == LOAD) && !rst;
    assign smp_valid = (state_q == REPLAY);
    assign smp_x     = smp_valid ? buf_rd_data[X_W-1:0] : '0;
    assign smp_y     = smp_valid ? buf_rd_data[SMP_W-1:X_W] : '0;
    assign smp_idx   = smp_valid ? rd_idx_q : '0;
    assign smp_last  = last_w;
    assign epoch     = epoch_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Scoreboard bench for perceptron_sample_loader: stimulus pushes expected
// transfers, a negedge monitor pops and compares on every handshake.
module tb_perceptron_sample_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  num_epochs;
    logic        clear;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_x;
    logic signed [7:0] smp_y;
    logic [1:0]  smp_idx;
    logic        smp_last;
    logic [7:0]  epoch;
    logic        done;

    typedef struct packed {
        logic [15:0] x;
        logic [7:0]  y;
        logic [1:0]  idx;
        logic [7:0]  ep;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: toggle, 2: driven by main
    logic [7:0]  cur [3][3];     // [sample][feature0, feature1, label]

    perceptron_sample_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .num_epochs (num_epochs),
        .clear      (clear),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_x      (smp_x),
        .smp_y      (smp_y),
        .smp_idx    (smp_idx),
        .smp_last   (smp_last),
        .epoch      (epoch),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Ready driver
    initial begin
        smp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) smp_ready = 1'b1;
            else if (rdy_mode == 1) smp_ready = !smp_ready;
        end
    end

    // Monitor: pops on every accepted transfer, checks stall stability and done timing
    initial begin
        exp_t        e;
        logic        stalled = 1'b0;
        logic        last_seen = 1'b0;
        logic [15:0] hx;
        logic [7:0]  hy;
        logic [1:0]  hi;
        forever begin
            @(negedge clk);
            if (last_seen) begin
                check("done_after_last", {31'd0, done}, 32'd1);
                check("valid_low_after_last", {31'd0, smp_valid}, 32'd0);
                last_seen = 1'b0;
            end
            if (stalled && smp_valid && !rst && !clear) begin
                check("stall_x", {16'd0, smp_x}, {16'd0, hx});
                check("stall_y", {24'd0, smp_y}, {24'd0, hy});
                check("stall_idx", {30'd0, smp_idx}, {30'd0, hi});
            end
            stalled = smp_valid && !smp_ready && !rst && !clear;
            hx = smp_x; hy = smp_y; hi = smp_idx;
            if (smp_valid && smp_ready && !rst && !clear) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_transfer", {30'd0, smp_idx}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    $display("xfer ep=%0d idx=%0d x=%04h y=%0d last=%0b", epoch, smp_idx, smp_x, smp_y, smp_last);
                    check("x", {16'd0, smp_x}, {16'd0, e.x});
                    check("y", {24'd0, smp_y}, {24'd0, e.y});
                    check("idx", {30'd0, smp_idx}, {30'd0, e.idx});
                    check("epoch", {24'd0, epoch}, {24'd0, e.ep});
                    check("last", {31'd0, smp_last}, {31'd0, e.last});
                    if (e.last) last_seen = 1'b1;
                end
            end
        end
    end

    task automatic set_data(input logic [7:0] a0, a1, ay, b0, b1, by, c0, c1, cy);
        cur[0][0] = a0; cur[0][1] = a1; cur[0][2] = ay;
        cur[1][0] = b0; cur[1][1] = b1; cur[1][2] = by;
        cur[2][0] = c0; cur[2][1] = c1; cur[2][2] = cy;
    endtask

    task automatic push_one(input int s, input int e, input logic last);
        exp_t t;
        t.x = {cur[s][1], cur[s][0]};
        t.y = cur[s][2];
        t.idx = 2'(s);
        t.ep = 8'(e);
        t.last = last;
        sb_q.push_back(t);
    endtask

    task automatic push_replay(input int eps);
        int eff = (eps == 0) ? 1 : eps;
        for (int e = 0; e < eff; e++)
            for (int s = 0; s < 3; s++)
                push_one(s, e, (e == eff - 1) && (s == 2));
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Load all three samples back to back, then confirm replay latency
    task automatic load_all();
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++)
            for (int b = 0; b < 3; b++) begin
                in_data = cur[s][b];
                @(posedge clk);
                #1;
            end
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", {31'd0, smp_valid}, 32'd1);
        check("latency_x0", {16'd0, smp_x}, {16'd0, cur[0][1], cur[0][0]});
        check("replay_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("sb_empty", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int found;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; num_epochs = 8'd1; clear = 1'b0;
        set_data(8'd2, 8'd3, 8'd0, 8'd4, 8'd5, 8'd1, 8'd1, 8'd2, 8'd1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_smp_valid", {31'd0, smp_valid}, 32'd0);
        check("rst_smp_x", {16'd0, smp_x}, 32'd0);
        check("rst_smp_y", {24'd0, smp_y}, 32'd0);
        check("rst_epoch", {24'd0, epoch}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_last", {31'd0, smp_last}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Load then replay, one epoch
        rdy_mode = 0; num_epochs = 8'd1;
        push_replay(1);
        load_all();
        wait_done();
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        do_clear();

        // Three epochs with toggling backpressure
        rdy_mode = 1; num_epochs = 8'd3;
        push_replay(3);
        load_all();
        wait_done();
        check("done_epoch_held", {24'd0, epoch}, 32'd2);
        do_clear();
        check("clear_done_low", {31'd0, done}, 32'd0);

        // num_epochs = 0 behaves as one pass
        rdy_mode = 0; num_epochs = 8'd0;
        push_replay(0);
        load_all();
        wait_done();
        do_clear();

        // clear discards a partially assembled sample
        num_epochs = 8'd1;
        send_byte(8'd7);
        send_byte(8'd8);
        do_clear();
        push_replay(1);
        load_all();
        wait_done();
        do_clear();

        // Signed extremes in labels and features, two epochs
        set_data(8'd9, 8'd10, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'd17, 8'd34, 8'd5);
        num_epochs = 8'd2;
        push_replay(2);
        load_all();
        wait_done();
        do_clear();

        // rst during epoch 1, idx 1: first four transfers only
        set_data(8'd2, 8'd3, 8'd0, 8'd4, 8'd5, 8'd1, 8'd1, 8'd2, 8'd1);
        num_epochs = 8'd3;
        push_one(0, 0, 1'b0); push_one(1, 0, 1'b0); push_one(2, 0, 1'b0); push_one(0, 1, 1'b0);
        load_all();
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            @(posedge clk);
            #2;
            if (smp_valid && epoch == 8'd1 && smp_idx == 2'd1) found = 1;
        end
        check("reached_ep1_idx1", found, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, smp_valid}, 32'd0);
        check("rst_mid_epoch", {24'd0, epoch}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_sb_empty", sb_q.size(), 32'd0);
        sb_q.delete();
        num_epochs = 8'd1;
        push_replay(1);
        load_all();
        wait_done();
        do_clear();

        // clear together with a handshake: transfer dropped, back to LOAD
        rdy_mode = 2; smp_ready = 1'b0; num_epochs = 8'd1;
        load_all();
        @(posedge clk);
        #2;
        smp_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        smp_ready = 1'b0;
        @(negedge clk);
        check("clr_hs_valid", {31'd0, smp_valid}, 32'd0);
        check("clr_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("clr_hs_done", {31'd0, done}, 32'd0);
        check("clr_hs_epoch", {24'd0, epoch}, 32'd0);
        rdy_mode = 0;
        push_replay(1);
        load_all();
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
